// File: rtl/obuf_loop_seq_if.sv
// Config, control and loop-event bundle between the obuf loop sequencer and its consumers.
// master is the sequencer side; slave is the configuring/consuming side.
interface obuf_loop_seq_if #(
    parameter int LOOP_ID_W     = 5,
    parameter int ADDR_STRIDE_W = 16,
    parameter int LOOP_ITER_W   = 16,
    parameter int ADDR_W        = 32
);
    logic                     start;
    logic                     stall;
    logic                     cfg_loop_v;
    logic [LOOP_ITER_W-1:0]   cfg_loop_iter;
    logic [ADDR_STRIDE_W-1:0] cfg_loop_stride;
    logic [ADDR_W-1:0]        cfg_base_addr;
    logic [ADDR_STRIDE_W-1:0] obuf_stride;
    logic                     obuf_stride_v;
    logic                     loop_enter;
    logic                     loop_exit;
    logic                     loop_index_valid;
    logic [LOOP_ID_W-1:0]     loop_index;
    logic                     loop_last_iter;
    logic                     loop_stall;
    logic [ADDR_W-1:0]        obuf_addr;
    logic                     obuf_addr_v;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, stall, cfg_loop_v, cfg_loop_iter, cfg_loop_stride, cfg_base_addr,
        output obuf_stride, obuf_stride_v, loop_enter, loop_exit, loop_index_valid,
               loop_index, loop_last_iter, loop_stall, obuf_addr, obuf_addr_v, busy, done
    );

    modport slave (
        output start, stall, cfg_loop_v, cfg_loop_iter, cfg_loop_stride, cfg_base_addr,
        input  obuf_stride, obuf_stride_v, loop_enter, loop_exit, loop_index_valid,
               loop_index, loop_last_iter, loop_stall, obuf_addr, obuf_addr_v, busy, done
    );
endinterface

// File: rtl/obuf_loop_seq.sv
// Nested-loop sequencer: one loop event per cycle decoded from registered state, first event the cycle after start.
// stall freezes state, counters and event outputs; only obuf_addr_v and loop_stall follow stall directly.
module obuf_loop_seq #(
    parameter int LOOP_ID_W     = 5,
    parameter int ADDR_STRIDE_W = 16,
    parameter int LOOP_ITER_W   = 16,
    parameter int ADDR_W        = 32
) (
    input  logic            clk,
    input  logic            reset,
    obuf_loop_seq_if.master bus
);
    localparam int MAX_LOOPS = 1 << LOOP_ID_W;
    localparam int NUM_W     = LOOP_ID_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_ENTER, S_ITER, S_EXIT, S_STEP, S_DONE} state_t;
    state_t state, next_state;

    logic [NUM_W-1:0]         num_loops;
    logic [LOOP_ID_W-1:0]     lvl;
    logic [ADDR_W-1:0]        base_addr;
    logic [LOOP_ITER_W-1:0]   iter_last  [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_tab [MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]   cnt        [MAX_LOOPS];
    logic [ADDR_W-1:0]        lvl_addr   [MAX_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_echo;
    logic                     stride_echo_v;

    logic              adv;
    logic              cur_last;
    logic              at_inner;
    logic              cfg_accept;
    logic [ADDR_W-1:0] stepped_addr;

    logic                 o_enter, o_exit, o_valid, o_last, o_addr_v, o_done;
    logic [LOOP_ID_W-1:0] o_index;
    logic [ADDR_W-1:0]    o_addr;

    assign adv          = !bus.stall;
    assign cur_last     = (cnt[lvl] == iter_last[lvl]);
    assign at_inner     = ({1'b0, lvl} == num_loops - 1'b1);
    assign stepped_addr = lvl_addr[lvl] + ADDR_W'(stride_tab[lvl]);
    // start wins over a same-cycle config write so the nest depth cannot change under a walk
    assign cfg_accept   = (state == S_IDLE) && bus.cfg_loop_v && !bus.start
                          && (num_loops != NUM_W'(MAX_LOOPS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_enter    = 1'b0;
        o_exit     = 1'b0;
        o_valid    = 1'b0;
        o_last     = 1'b0;
        o_addr_v   = 1'b0;
        o_done     = 1'b0;
        o_index    = '0;
        o_addr     = '0;
        case (state)
            S_IDLE: begin
                if (bus.start) next_state = (num_loops == '0) ? S_DONE : S_ENTER;
            end
            S_ENTER: begin
                o_enter = 1'b1;
                o_index = lvl;
                if (adv && at_inner) next_state = S_ITER;
            end
            S_ITER: begin
                o_valid  = 1'b1;
                o_index  = lvl;
                o_last   = cur_last;
                o_addr_v = adv;
                o_addr   = lvl_addr[lvl];
                if (adv && cur_last) next_state = S_EXIT;
            end
            S_EXIT: begin
                o_exit  = 1'b1;
                o_index = lvl;
                if (adv) next_state = (lvl == '0) ? S_DONE : S_STEP;
            end
            S_STEP: begin
                o_valid = 1'b1;
                o_index = lvl;
                o_last  = cur_last;
                if (adv) next_state = cur_last ? S_EXIT : S_ENTER;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (adv) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // lvl_addr[i] tracks base + sum of cnt[0..i]*stride[0..i] along the current path
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_loops     <= '0;
            lvl           <= '0;
            base_addr     <= '0;
            stride_echo   <= '0;
            stride_echo_v <= 1'b0;
            for (int i = 0; i < MAX_LOOPS; i++) begin
                iter_last[i]  <= '0;
                stride_tab[i] <= '0;
                cnt[i]        <= '0;
                lvl_addr[i]   <= '0;
            end
        end else begin
            stride_echo_v <= cfg_accept;
            if (cfg_accept) begin
                iter_last[num_loops[LOOP_ID_W-1:0]]  <= (bus.cfg_loop_iter == '0) ? '0
                                                        : bus.cfg_loop_iter - 1'b1;
                stride_tab[num_loops[LOOP_ID_W-1:0]] <= bus.cfg_loop_stride;
                stride_echo                          <= bus.cfg_loop_stride;
                num_loops                            <= num_loops + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        base_addr <= bus.cfg_base_addr;
                        lvl       <= '0;
                    end
                end
                S_ENTER: begin
                    if (adv) begin
                        cnt[lvl]      <= '0;
                        lvl_addr[lvl] <= (lvl == '0) ? base_addr : lvl_addr[lvl - 1'b1];
                        if (!at_inner) lvl <= lvl + 1'b1;
                    end
                end
                S_ITER: begin
                    if (adv && !cur_last) begin
                        cnt[lvl]      <= cnt[lvl] + 1'b1;
                        lvl_addr[lvl] <= stepped_addr;
                    end
                end
                S_EXIT: begin
                    if (adv && (lvl != '0)) lvl <= lvl - 1'b1;
                end
                S_STEP: begin
                    if (adv && !cur_last) begin
                        cnt[lvl]      <= cnt[lvl] + 1'b1;
                        lvl_addr[lvl] <= stepped_addr;
                        lvl           <= lvl + 1'b1;
                    end
                end
                S_DONE: begin
                    if (adv) num_loops <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.obuf_stride      = stride_echo;
    assign bus.obuf_stride_v    = stride_echo_v;
    assign bus.loop_enter       = o_enter;
    assign bus.loop_exit        = o_exit;
    assign bus.loop_index_valid = o_valid;
    assign bus.loop_index       = o_index;
    assign bus.loop_last_iter   = o_last;
    assign bus.obuf_addr        = o_addr;
    assign bus.obuf_addr_v      = o_addr_v;
    assign bus.busy             = (state != S_IDLE);
    assign bus.loop_stall       = bus.stall && (state != S_IDLE);
    assign bus.done             = o_done;
endmodule

// File: tb/tb_obuf_loop_seq.sv
// Directed bench for obuf_loop_seq: hand-computed event tables and address sequences per scenario.
module tb_obuf_loop_seq;
    logic clk;
    logic reset;

    obuf_loop_seq_if bus ();
    obuf_loop_seq dut (.clk(clk), .reset(reset), .bus(bus));

    int checks;
    int errors;
    logic [10:0] walk_ev   [15];
    logic [31:0] walk_addr [6];
    logic [31:0] seen_addr [64];
    int n_seen, n_enter, n_exit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {addr_v, enter, exit, index_valid, last_iter, done, index}
    function automatic logic [10:0] ev(input bit av, en, ex, va, la, dn, input int idx);
        return {av, en, ex, va, la, dn, 5'(idx)};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.obuf_addr_v, bus.loop_enter, bus.loop_exit, bus.loop_index_valid,
                bus.loop_last_iter, bus.done, bus.loop_index};
    endfunction

    function automatic logic [61:0] all_out();
        return {bus.obuf_stride, bus.obuf_stride_v, bus.loop_enter, bus.loop_exit,
                bus.loop_index_valid, bus.loop_index, bus.loop_last_iter, bus.loop_stall,
                bus.obuf_addr, bus.obuf_addr_v, bus.busy, bus.done};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [15:0] iter, input logic [15:0] stride);
        bus.cfg_loop_v      = 1'b1;
        bus.cfg_loop_iter   = iter;
        bus.cfg_loop_stride = stride;
        next();
        bus.cfg_loop_v = 1'b0;
    endtask

    task automatic cfg_nest2();
        cfg(16'd2, 16'd10);
        cfg(16'd3, 16'd1);
    endtask

    // Pulses start in cycle 0 and records events until done or the cycle budget runs out.
    task automatic run_walk(input logic [31:0] base, input int max_cyc, output int done_cyc);
        n_seen = 0; n_enter = 0; n_exit = 0; done_cyc = -1;
        bus.cfg_base_addr = base;
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        for (int c = 1; c <= max_cyc && done_cyc < 0; c++) begin
            #1;
            if (bus.loop_enter) n_enter++;
            if (bus.loop_exit) n_exit++;
            if (bus.obuf_addr_v && n_seen < 64) begin
                seen_addr[n_seen] = bus.obuf_addr;
                n_seen++;
            end
            if (bus.done) done_cyc = c;
            next();
        end
    endtask

    task automatic load_tables();
        walk_ev = '{ev(0,1,0,0,0,0,0), ev(0,1,0,0,0,0,1), ev(1,0,0,1,0,0,1), ev(1,0,0,1,0,0,1),
                    ev(1,0,0,1,1,0,1), ev(0,0,1,0,0,0,1), ev(0,0,0,1,0,0,0), ev(0,1,0,0,0,0,1),
                    ev(1,0,0,1,0,0,1), ev(1,0,0,1,0,0,1), ev(1,0,0,1,1,0,1), ev(0,0,1,0,0,0,1),
                    ev(0,0,0,1,1,0,0), ev(0,0,1,0,0,0,0), ev(0,0,0,0,0,1,0)};
        walk_addr = '{32'd100, 32'd101, 32'd102, 32'd110, 32'd111, 32'd112};
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (all_out() !== '0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", all_out());
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++; $display("FAIL idle_after_reset got %h want 0", all_out());
        end
        next();
    endtask

    task automatic test_basic_walk();
        int na;
        cfg_nest2();
        bus.cfg_base_addr = 32'd100;
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        na = 0;
        for (int c = 1; c <= 15; c++) begin
            bus.start           = (c == 5);
            bus.cfg_loop_v      = (c == 7);
            bus.cfg_loop_stride = 16'd77;
            #1;
            checks++;
            if (obs() !== walk_ev[c-1]) begin
                errors++; $display("FAIL walk_event cycle %0d got %b want %b", c, obs(), walk_ev[c-1]);
            end
            if (bus.obuf_addr_v) begin
                checks++;
                if (na > 5) begin
                    errors++; $display("FAIL walk_addr extra address %0d at cycle %0d", bus.obuf_addr, c);
                end else if (bus.obuf_addr !== walk_addr[na]) begin
                    errors++; $display("FAIL walk_addr #%0d got %0d want %0d", na, bus.obuf_addr, walk_addr[na]);
                end
                na++;
            end
            if (c == 8) begin
                checks++;
                if (bus.obuf_stride_v !== 1'b0) begin
                    errors++; $display("FAIL busy_cfg_ignored echo_v got %b want 0", bus.obuf_stride_v);
                end
            end
            next();
        end
        bus.start = 1'b0; bus.cfg_loop_v = 1'b0;
        checks++;
        if (na != 6) begin
            errors++; $display("FAIL walk_addr_count got %0d want 6", na);
        end
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL walk_idle busy/done got %b want 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_stall();
        logic [10:0] want;
        logic st;
        cfg_nest2();
        bus.cfg_base_addr = 32'd100;
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        n_seen = 0;
        for (int c = 1; c <= 18; c++) begin
            st = (c >= 4 && c <= 6);
            bus.stall = st;
            #1;
            if (st) want = walk_ev[3] & 11'h3FF;
            else if (c < 4) want = walk_ev[c-1];
            else want = walk_ev[c-4];
            checks++;
            if ({bus.loop_stall, obs()} !== {st, want}) begin
                errors++; $display("FAIL stall_event cycle %0d got %b want %b", c, {bus.loop_stall, obs()}, {st, want});
            end
            if (st) begin
                checks++;
                if (bus.obuf_addr !== 32'd101) begin
                    errors++; $display("FAIL stall_addr_hold cycle %0d got %0d want 101", c, bus.obuf_addr);
                end
            end
            if (bus.obuf_addr_v && n_seen < 64) begin
                seen_addr[n_seen] = bus.obuf_addr;
                n_seen++;
            end
            next();
        end
        bus.stall = 1'b0;
        checks++;
        if (n_seen != 6) begin
            errors++; $display("FAIL stall_addr_count got %0d want 6", n_seen);
        end
        for (int i = 0; i < n_seen && i < 6; i++) begin
            checks++;
            if (seen_addr[i] !== walk_addr[i]) begin
                errors++; $display("FAIL stall_addr #%0d got %0d want %0d", i, seen_addr[i], walk_addr[i]);
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL stall_end busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_empty_start();
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.busy, obs()} !== {1'b1, ev(0,0,0,0,0,1,0)}) begin
            errors++; $display("FAIL empty_done got %b want %b", {bus.busy, obs()}, {1'b1, ev(0,0,0,0,0,1,0)});
        end
        next();
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL empty_idle busy/done got %b want 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_cfg_echo_zero_iter();
        int dc;
        cfg(16'd0, 16'd0);
        checks++;
        if ({bus.obuf_stride_v, bus.obuf_stride} !== {1'b1, 16'd0}) begin
            errors++; $display("FAIL echo_0 got %b/%0d want 1/0", bus.obuf_stride_v, bus.obuf_stride);
        end
        cfg(16'd2, 16'd4);
        checks++;
        if ({bus.obuf_stride_v, bus.obuf_stride} !== {1'b1, 16'd4}) begin
            errors++; $display("FAIL echo_1 got %b/%0d want 1/4", bus.obuf_stride_v, bus.obuf_stride);
        end
        cfg(16'd1, 16'd0);
        checks++;
        if ({bus.obuf_stride_v, bus.obuf_stride} !== {1'b1, 16'd0}) begin
            errors++; $display("FAIL echo_2 got %b/%0d want 1/0", bus.obuf_stride_v, bus.obuf_stride);
        end
        next();
        checks++;
        if (bus.obuf_stride_v !== 1'b0) begin
            errors++; $display("FAIL echo_one_cycle got %b want 0", bus.obuf_stride_v);
        end
        run_walk(32'd8, 40, dc);
        checks++;
        if ({dc, n_enter, n_exit, n_seen} !== {32'd14, 32'd4, 32'd4, 32'd2}) begin
            errors++; $display("FAIL zero_iter done/enter/exit/addrs got %0d/%0d/%0d/%0d want 14/4/4/2", dc, n_enter, n_exit, n_seen);
        end
        checks++;
        if ({seen_addr[0], seen_addr[1]} !== {32'd8, 32'd12}) begin
            errors++; $display("FAIL zero_iter_addr got %0d,%0d want 8,12", seen_addr[0], seen_addr[1]);
        end
    endtask

    task automatic test_max_loops();
        int dc;
        for (int i = 0; i < 33; i++) begin
            cfg(16'd1, 16'd1);
            if (i == 31) begin
                checks++;
                if (bus.obuf_stride_v !== 1'b1) begin
                    errors++; $display("FAIL max_last_echo got %b want 1", bus.obuf_stride_v);
                end
            end else if (i == 32) begin
                checks++;
                if (bus.obuf_stride_v !== 1'b0) begin
                    errors++; $display("FAIL max_dropped_echo got %b want 0", bus.obuf_stride_v);
                end
            end
        end
        run_walk(32'd5, 200, dc);
        checks++;
        if ({dc, n_enter, n_exit, n_seen} !== {32'd97, 32'd32, 32'd32, 32'd1}) begin
            errors++; $display("FAIL max_walk done/enter/exit/addrs got %0d/%0d/%0d/%0d want 97/32/32/1", dc, n_enter, n_exit, n_seen);
        end
        checks++;
        if (seen_addr[0] !== 32'd5) begin
            errors++; $display("FAIL max_addr got %0d want 5", seen_addr[0]);
        end
    endtask

    task automatic test_reset_mid_walk();
        int dc;
        cfg_nest2();
        bus.cfg_base_addr = 32'd100;
        bus.start = 1'b1;
        next();
        bus.start = 1'b0;
        next(); next(); next();
        #1;
        checks++;
        if (obs() !== walk_ev[3]) begin
            errors++; $display("FAIL pre_reset_iter got %b want %b", obs(), walk_ev[3]);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (all_out() !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got %h want 0", all_out());
        end
        next();
        reset = 1'b1;
        next();
        run_walk(32'd7, 10, dc);
        checks++;
        if ({dc, n_enter} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL config_lost done/enter got %0d/%0d want 1/0", dc, n_enter);
        end
        cfg_nest2();
        run_walk(32'd100, 40, dc);
        checks++;
        if ({dc, n_seen} !== {32'd15, 32'd6}) begin
            errors++; $display("FAIL rerun done/addrs got %0d/%0d want 15/6", dc, n_seen);
        end
        for (int i = 0; i < n_seen && i < 6; i++) begin
            checks++;
            if (seen_addr[i] !== walk_addr[i]) begin
                errors++; $display("FAIL rerun_addr #%0d got %0d want %0d", i, seen_addr[i], walk_addr[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.cfg_loop_v = 1'b0;
        bus.cfg_loop_iter = '0;
        bus.cfg_loop_stride = '0;
        bus.cfg_base_addr = '0;
        load_tables();
        test_reset();
        test_basic_walk();
        test_stall();
        test_empty_start();
        test_cfg_echo_zero_iter();
        test_max_loops();
        test_reset_mid_walk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
